// File: rtl/bram_if_pipe_if.sv
// Host-side bus bundle for bram_if_pipe: access strobe, byte enables, address,
// write data, read result with valid/error flags, and the ready indication.
interface bram_if_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic                  en;
  logic [DATA_W/8-1:0]   wen;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     din;
  logic [DATA_W-1:0]     dout;
  logic                  dout_valid;
  logic                  addr_err;
  logic                  ready;

  modport master (
    output en, wen, addr, din,
    input  dout, dout_valid, addr_err, ready
  );

  modport slave (
    input  en, wen, addr, din,
    output dout, dout_valid, addr_err, ready
  );
endinterface

// File: rtl/bram_if_pipe.sv
// Byte-addressed single-port BRAM with byte enables, 1/2-cycle read latency,
// range checking and post-reset clear. Optional macro: BRAM_IF_PIPE_BYPASS_EN.
module bram_if_pipe #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 10240,
  parameter int ADDR_W       = 32,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic          clk,
  input  logic          rst,
  bram_if_pipe_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("bram_if_pipe: RD_LAT must be 1 or 2");
  end

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  clr_q, clr_d;
  logic              ready;
  logic              accept;
  logic [ADDR_W-1:0] word_idx;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] rd_word;

  assign ready    = (state_q == ST_RUN) && rst;
  assign accept   = bus.en && ready;
  assign word_idx = bus.addr >> OFF_W;
  assign in_range = (word_idx < DEPTH_A);
  assign idx      = word_idx[IDX_W-1:0];

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    case (state_q)
      ST_RST: begin
        clr_d   = '0;
        state_d = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
      end
      ST_CLEAR: begin
        if (clr_q == LAST_IDX) state_d = ST_RUN;
        else                   clr_d   = clr_q + 1'b1;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RST;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RST;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; only the clear sequencer or host writes touch it.
  always_ff @(posedge clk) begin
    if (rst && state_q == ST_CLEAR) begin
      mem[clr_q] <= '0;
    end else if (accept && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wen[b]) mem[idx][8*b +: 8] <= bus.din[8*b +: 8];
      end
    end
  end

  assign old_word = in_range ? mem[idx] : '0;

`ifdef BRAM_IF_PIPE_BYPASS_EN
  // Write-first: enabled bytes of the same-cycle write replace the stored bytes.
  always_comb begin
    rd_word = old_word;
    for (int b = 0; b < NB; b++) begin
      if (in_range && bus.wen[b]) rd_word[8*b +: 8] = bus.din[8*b +: 8];
    end
  end
`else
  assign rd_word = old_word;
`endif

  logic              v1_q, e1_q;
  logic [DATA_W-1:0] d1_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q <= 1'b0;
      e1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= accept;
      e1_q <= accept && !in_range;
      if (accept) d1_q <= rd_word;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              v2_q, e2_q;
    logic [DATA_W-1:0] d2_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        v2_q <= 1'b0;
        e2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        e2_q <= e1_q;
        if (v1_q) d2_q <= d1_q;
      end
    end

    assign bus.dout       = d2_q;
    assign bus.dout_valid = v2_q;
    assign bus.addr_err   = e2_q;
  end else begin : g_lat1
    assign bus.dout       = d1_q;
    assign bus.dout_valid = v1_q;
    assign bus.addr_err   = e1_q;
  end

  assign bus.ready = ready;
endmodule

// File: tb/tb_bram_if_pipe.sv
// Drives a RD_LAT=1/clear instance and a RD_LAT=2/no-clear instance (DEPTH=16)
// with shared stimulus and checks both against hand-computed expectations.
module tb_bram_if_pipe;
`ifdef BRAM_IF_PIPE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [3:0]  wen = '0;
  logic [31:0] addr = '0;
  logic [31:0] din  = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bram_if_pipe_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();
  bram_if_pipe_if #(.DATA_W(32), .ADDR_W(32)) bus2 ();

  assign bus1.en = en;  assign bus1.wen = wen;  assign bus1.addr = addr;  assign bus1.din = din;
  assign bus2.en = en;  assign bus2.wen = wen;  assign bus2.addr = addr;  assign bus2.din = din;

  bram_if_pipe #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .RD_LAT(1), .CLEAR_ON_RST(1))
    u1 (.clk(clk), .rst(rst), .bus(bus1));
  bram_if_pipe #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .RD_LAT(2), .CLEAR_ON_RST(0))
    u2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        v;
    logic        e;
    logic        c2;
  } vec_t;

  vec_t tv[22];

  function automatic vec_t mk(logic e_n, logic [3:0] w, logic [31:0] a, logic [31:0] d,
                              logic [31:0] q, logic v, logic e, logic c2);
    vec_t r;
    r.en = e_n; r.wen = w; r.addr = a; r.din = d;
    r.dout = q; r.v = v; r.e = e; r.c2 = c2;
    return r;
  endfunction

  function automatic logic [31:0] sel(logic [31:0] byp_val, logic [31:0] rf_val);
    return BYP ? byp_val : rf_val;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e_n, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d);
    en = e_n; wen = w; addr = a; din = d;
  endtask

  initial begin
    tv[0]  = mk(1, 4'h0, 32'h00, 32'h0,        32'h0,                                  1, 0, 0);
    tv[1]  = mk(1, 4'h0, 32'h3C, 32'h0,        32'h0,                                  1, 0, 0);
    tv[2]  = mk(1, 4'hF, 32'h10, 32'hDEADBEEF, sel(32'hDEADBEEF, 32'h0),               1, 0, 0);
    tv[3]  = mk(1, 4'h2, 32'h10, 32'h0000AA00, sel(32'hDEADAAEF, 32'hDEADBEEF),        1, 0, 1);
    tv[4]  = mk(1, 4'h0, 32'h10, 32'h0,        32'hDEADAAEF,                           1, 0, 1);
    tv[5]  = mk(1, 4'h0, 32'h12, 32'h0,        32'hDEADAAEF,                           1, 0, 1);
    tv[6]  = mk(1, 4'hF, 32'h40, 32'h12345678, 32'h0,                                  1, 1, 1);
    tv[7]  = mk(1, 4'h0, 32'h00, 32'h0,        32'h0,                                  1, 0, 0);
    tv[8]  = mk(1, 4'hF, 32'h00, 32'h1,        sel(32'h1, 32'h0),                      1, 0, 0);
    tv[9]  = mk(1, 4'hF, 32'h04, 32'h2,        sel(32'h2, 32'h0),                      1, 0, 0);
    tv[10] = mk(1, 4'hF, 32'h08, 32'h3,        sel(32'h3, 32'h0),                      1, 0, 0);
    tv[11] = mk(1, 4'h0, 32'h00, 32'h0,        32'h1,                                  1, 0, 1);
    tv[12] = mk(1, 4'h0, 32'h04, 32'h0,        32'h2,                                  1, 0, 1);
    tv[13] = mk(1, 4'h0, 32'h08, 32'h0,        32'h3,                                  1, 0, 1);
    tv[14] = mk(0, 4'hF, 32'h10, 32'hFFFFFFFF, 32'h3,                                  0, 0, 1);
    tv[15] = mk(1, 4'h0, 32'h10, 32'h0,        32'hDEADAAEF,                           1, 0, 1);
    tv[16] = mk(1, 4'hF, 32'h08, 32'h11111111, sel(32'h11111111, 32'h3),               1, 0, 1);
    tv[17] = mk(1, 4'hF, 32'h08, 32'h22222222, sel(32'h22222222, 32'h11111111),        1, 0, 1);
    tv[18] = mk(1, 4'h0, 32'h08, 32'h0,        32'h22222222,                           1, 0, 1);
    tv[19] = mk(1, 4'h0, 32'h3C, 32'h0,        32'h0,                                  1, 0, 0);
    tv[20] = mk(1, 4'h0, 32'h44, 32'h0,        32'h0,                                  1, 1, 1);
    tv[21] = mk(0, 4'h0, 32'h00, 32'h0,        32'h0,                                  0, 0, 1);

    // Reset held for three edges.
    rst = 1'b0;
    drive(0, 4'h0, 32'h0, 32'h0);
    repeat (3) tick();
    check("rst_ready1", {31'b0, bus1.ready}, 32'd0);
    check("rst_ready2", {31'b0, bus2.ready}, 32'd0);
    check("rst_dout1",  bus1.dout, 32'h0);
    check("rst_dout2",  bus2.dout, 32'h0);
    check("rst_valid1", {31'b0, bus1.dout_valid}, 32'd0);
    check("rst_err2",   {31'b0, bus2.addr_err}, 32'd0);

    // Release: no-clear instance ready after one edge, clearing one after DEPTH+1.
    rst = 1'b1;
    tick();
    check("rel_ready2_e1", {31'b0, bus2.ready}, 32'd1);
    check("rel_ready1_e1", {31'b0, bus1.ready}, 32'd0);
    for (int k = 2; k <= 16; k++) begin
      tick();
      check($sformatf("clr_ready1_e%0d", k), {31'b0, bus1.ready}, 32'd0);
    end
    tick();
    check("clr_ready1_e17", {31'b0, bus1.ready}, 32'd1);

    // Vector table: u1 result after one edge, u2 result one edge later.
    for (int i = 0; i < 22; i++) begin
      drive(tv[i].en, tv[i].wen, tv[i].addr, tv[i].din);
      tick();
      check($sformatf("v%0d_dout1", i),  bus1.dout, tv[i].dout);
      check($sformatf("v%0d_valid1", i), {31'b0, bus1.dout_valid}, {31'b0, tv[i].v});
      check($sformatf("v%0d_err1", i),   {31'b0, bus1.addr_err}, {31'b0, tv[i].e});
      if (i > 0 && tv[i-1].c2) begin
        check($sformatf("v%0d_dout2", i-1),  bus2.dout, tv[i-1].dout);
        check($sformatf("v%0d_valid2", i-1), {31'b0, bus2.dout_valid}, {31'b0, tv[i-1].v});
        check($sformatf("v%0d_err2", i-1),   {31'b0, bus2.addr_err}, {31'b0, tv[i-1].e});
      end
    end
    drive(0, 4'h0, 32'h0, 32'h0);
    tick();
    check("v21_dout2",  bus2.dout, tv[21].dout);
    check("v21_valid2", {31'b0, bus2.dout_valid}, 32'd0);

    // Reset while a read is in flight in the 2-stage pipeline: no valid pulse.
    drive(1, 4'h0, 32'h04, 32'h0);
    tick();
    drive(0, 4'h0, 32'h0, 32'h0);
    rst = 1'b0;
    tick();
    check("flush_valid2", {31'b0, bus2.dout_valid}, 32'd0);
    check("flush_valid1", {31'b0, bus1.dout_valid}, 32'd0);
    check("flush_dout2",  bus2.dout, 32'h0);
    check("flush_ready1", {31'b0, bus1.ready}, 32'd0);
    tick();

    // Start a clear, abort it at word 5 with reads issued during it.
    rst = 1'b1;
    drive(1, 4'h0, 32'h00, 32'h0);
    tick();
    for (int k = 2; k <= 6; k++) begin
      tick();
      check($sformatf("abort_valid1_e%0d", k), {31'b0, bus1.dout_valid}, 32'd0);
    end
    rst = 1'b0;
    drive(0, 4'h0, 32'h0, 32'h0);
    tick();
    check("abort_ready1", {31'b0, bus1.ready}, 32'd0);

    // Restarted clear runs the full DEPTH cycles; reads are dropped.
    rst = 1'b1;
    drive(1, 4'h0, 32'h08, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("reclr_ready1_e%0d", k), {31'b0, bus1.ready}, 32'd0);
      check($sformatf("reclr_valid1_e%0d", k), {31'b0, bus1.dout_valid}, 32'd0);
    end
    drive(0, 4'h0, 32'h0, 32'h0);
    tick();
    check("reclr_ready1_e17", {31'b0, bus1.ready}, 32'd1);

    // Words written earlier are zero after the complete clear.
    drive(1, 4'h0, 32'h08, 32'h0);
    tick();
    check("post_clr_w2",     bus1.dout, 32'h0);
    check("post_clr_valid",  {31'b0, bus1.dout_valid}, 32'd1);
    drive(1, 4'h0, 32'h10, 32'h0);
    tick();
    check("post_clr_w4",     bus1.dout, 32'h0);
    drive(0, 4'h0, 32'h0, 32'h0);
    tick();
    check("post_clr_idle",   {31'b0, bus1.dout_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
